// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Execution sequencer for the 5-stage MIPS pipeline. It generates the PC and
// pipeline-register write enables, the IF/ID flush and the ID/EX bubble. It
// supports continuous and single-step execution, load-use stalls and branch
// flushes. After a HALT is fetched it drains the pipeline so that HALT retires
// through WB, and then it freezes in DONE until reset.
//
// Optional feature macro: PIPE_CYCLE_COUNT_EN
//   defined   -> an NB_CNT-bit saturating advance counter drives o_cycle_count
//   undefined -> no counter register is built and o_cycle_count is tied to 0
//
// Parameters
//   NB_CNT        width of the executed-cycle counter
//   DRAIN_CYCLES  advances after the HALT-fetch advance that retire HALT
//
// Ports
//   i_clock            pipeline clock, rising edge
//   i_reset            asynchronous active-high reset
//   i_mode_step        1 = single-step, 0 = continuous (latched on start)
//   i_start            start pulse, accepted only in IDLE
//   i_step             one advance per cycle high, step mode only
//   i_halt_fetched     IF stage holds a HALT opcode
//   i_load_use_hazard  stall request from the hazard unit
//   i_branch_taken     branch/jump resolved taken in ID
//   o_pc_en            PC write enable
//   o_if_id_en         IF/ID write enable
//   o_pipe_en          ID/EX, EX/MEM, MEM/WB write enable
//   o_if_id_flush      load NOP into IF/ID on this advance
//   o_id_ex_bubble     load NOP controls into ID/EX on this advance
//   o_running          registered: RUN, STEP_WAIT or DRAIN
//   o_done             registered: DONE
//   o_cycle_count      registered: advances since reset (saturating)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int NB_CNT       = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_mode_step,
   input  logic              i_start,
   input  logic              i_step,
   input  logic              i_halt_fetched,
   input  logic              i_load_use_hazard,
   input  logic              i_branch_taken,
   output logic              o_pc_en,
   output logic              o_if_id_en,
   output logic              o_pipe_en,
   output logic              o_if_id_flush,
   output logic              o_id_ex_bubble,
   output logic              o_running,
   output logic              o_done,
   output logic [NB_CNT-1:0] o_cycle_count
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RUN       = 3'd1;
   localparam logic [2:0] ST_STEP_WAIT = 3'd2;
   localparam logic [2:0] ST_DRAIN     = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   // Keep the drain counter at least one bit wide even for DRAIN_CYCLES = 1.
   localparam int                  NB_DRAIN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

   logic [2:0]          r_state;
   logic [2:0]          w_state_next;
   logic                r_mode_step;
   logic                w_mode_next;
   logic [NB_DRAIN-1:0] r_drain_cnt;
   logic [NB_DRAIN-1:0] w_drain_next;
   logic                r_running;
   logic                r_done;
   logic                w_advance;

   // An advance happens every cycle in RUN. In STEP_WAIT and DRAIN it waits
   // for i_step only when step mode was latched at start.
   always_comb begin
      w_advance = 1'b0;
      case (r_state)
         ST_RUN:                w_advance = 1'b1;
         ST_STEP_WAIT, ST_DRAIN: w_advance = r_mode_step ? i_step : 1'b1;
         default:               w_advance = 1'b0;
      endcase
   end

   // Enables, flush and bubble. All of them stay 0 outside an advance.
   always_comb begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_pipe_en      = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;
      if (w_advance) begin
         if (r_state == ST_DRAIN) begin
            // Freeze the PC and feed NOPs behind HALT while it retires.
            o_if_id_en    = 1'b1;
            o_if_id_flush = 1'b1;
            o_pipe_en     = 1'b1;
         end else if (i_load_use_hazard) begin
            // The stall wins over a branch: the branch re-resolves on the
            // next advance, so its flush must not discard the held IF/ID.
            o_pipe_en      = 1'b1;
            o_id_ex_bubble = 1'b1;
         end else begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_pipe_en     = 1'b1;
            o_if_id_flush = i_branch_taken;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_mode_next  = r_mode_step;
      w_drain_next = r_drain_cnt;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_mode_next  = i_mode_step;
               w_state_next = i_mode_step ? ST_STEP_WAIT : ST_RUN;
            end
         end
         ST_RUN, ST_STEP_WAIT: begin
            // A HALT seen during a stall is not yet accepted into IF/ID.
            if (w_advance && i_halt_fetched && !i_load_use_hazard) begin
               w_state_next = ST_DRAIN;
               w_drain_next = '0;
            end
         end
         ST_DRAIN: begin
            if (w_advance) begin
               if (r_drain_cnt == DRAIN_LAST) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_drain_next = r_drain_cnt + NB_DRAIN'(1);
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_DONE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_mode_step <= 1'b0;
         r_drain_cnt <= '0;
         r_running   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_mode_step <= w_mode_next;
         r_drain_cnt <= w_drain_next;
         r_running   <= (w_state_next == ST_RUN) || (w_state_next == ST_STEP_WAIT) ||
                        (w_state_next == ST_DRAIN);
         r_done      <= (w_state_next == ST_DONE);
      end
   end

   assign o_running = r_running;
   assign o_done    = r_done;

`ifdef PIPE_CYCLE_COUNT_EN
   logic [NB_CNT-1:0] r_cycle_count;

   // Advances only occur in RUN, STEP_WAIT and DRAIN, so the counter holds in
   // IDLE and DONE without an explicit state check.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cycle_count <= '0;
      end else if (w_advance && (r_cycle_count != '1)) begin
         r_cycle_count <= r_cycle_count + NB_CNT'(1);
      end
   end

   assign o_cycle_count = r_cycle_count;
`else
   assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl. A behavioural model, which tracks
// the execution phase, the remaining drain advances and the advance count,
// is checked against the DUT on every falling edge. Directed scenarios pin the
// model with hand-computed literals. They are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int DRAIN = 4;
`ifdef PIPE_CYCLE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_mode_step = 1'b0;
   logic        i_start = 1'b0;
   logic        i_step = 1'b0;
   logic        i_halt_fetched = 1'b0;
   logic        i_load_use_hazard = 1'b0;
   logic        i_branch_taken = 1'b0;
   logic        o_pc_en, o_if_id_en, o_pipe_en, o_if_id_flush, o_id_ex_bubble;
   logic        o_running, o_done;
   logic [31:0] o_cycle_count;

   always #5 clk = ~clk;

   pipeline_ctrl #(.NB_CNT(32), .DRAIN_CYCLES(DRAIN)) dut (
      .i_clock          (clk),
      .i_reset          (i_reset),
      .i_mode_step      (i_mode_step),
      .i_start          (i_start),
      .i_step           (i_step),
      .i_halt_fetched   (i_halt_fetched),
      .i_load_use_hazard(i_load_use_hazard),
      .i_branch_taken   (i_branch_taken),
      .o_pc_en          (o_pc_en),
      .o_if_id_en       (o_if_id_en),
      .o_pipe_en        (o_pipe_en),
      .o_if_id_flush    (o_if_id_flush),
      .o_id_ex_bubble   (o_id_ex_bubble),
      .o_running        (o_running),
      .o_done           (o_done),
      .o_cycle_count    (o_cycle_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = not started, 1 = executing, 2 = draining, 3 = finished
   int     m_phase      = 0;
   bit     m_mode       = 1'b0;
   int     m_drain_left = 0;
   longint m_count      = 0;

   always @(negedge clk) begin
      logic       adv;
      logic [4:0] e;   // {pc, if_id, pipe, flush, bubble}
      if (i_reset) begin
         check("rst_pc_en", o_pc_en, 0);
         check("rst_if_id_en", o_if_id_en, 0);
         check("rst_pipe_en", o_pipe_en, 0);
         check("rst_flush", o_if_id_flush, 0);
         check("rst_bubble", o_id_ex_bubble, 0);
         check("rst_running", o_running, 0);
         check("rst_done", o_done, 0);
         check("rst_count", o_cycle_count, 0);
         m_phase = 0; m_mode = 1'b0; m_drain_left = 0; m_count = 0;
      end else begin
         check("m_running", o_running, (m_phase == 1 || m_phase == 2) ? 1 : 0);
         check("m_done", o_done, (m_phase == 3) ? 1 : 0);
         check("m_count", o_cycle_count, CNT_EN ? m_count[31:0] : 32'd0);
         adv = (m_phase == 1 || m_phase == 2) && (!m_mode || i_step);
         e = 5'b00000;
         if (adv && m_phase == 2)
            e = 5'b01110;
         else if (adv && i_load_use_hazard)
            e = 5'b00101;
         else if (adv)
            e = {3'b111, i_branch_taken, 1'b0};
         check("m_pc_en", o_pc_en, e[4]);
         check("m_if_id_en", o_if_id_en, e[3]);
         check("m_pipe_en", o_pipe_en, e[2]);
         check("m_flush", o_if_id_flush, e[1]);
         check("m_bubble", o_id_ex_bubble, e[0]);
         // state the upcoming rising edge will establish
         if (m_phase == 0) begin
            if (i_start) begin
               m_phase = 1;
               m_mode  = i_mode_step;
            end
         end else if (adv) begin
            if (m_count < 64'hFFFF_FFFF) m_count++;
            if (m_phase == 1) begin
               if (i_halt_fetched && !i_load_use_hazard) begin
                  m_phase      = 2;
                  m_drain_left = DRAIN;
               end
            end else begin
               m_drain_left--;
               if (m_drain_left == 0) m_phase = 3;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int t_pc, t_pipe, t_flush;

   // One clock cycle: drive just after the rising edge, sample mid-cycle.
   task automatic cyc(input logic st = 0, input logic sp = 0, input logic md = 0,
                      input logic ht = 0, input logic lu = 0, input logic br = 0,
                      input logic rs = 0);
      @(posedge clk);
      #1;
      i_start = st; i_step = sp; i_mode_step = md; i_halt_fetched = ht;
      i_load_use_hazard = lu; i_branch_taken = br; i_reset = rs;
      #3;
      if (o_pc_en) t_pc++;
      if (o_pipe_en) t_pipe++;
      if (o_if_id_flush) t_flush++;
   endtask

   task automatic clr_tally();
      t_pc = 0; t_pipe = 0; t_flush = 0;
   endtask

   initial begin
      cyc(.rs(1));
      check("reset_running", o_running, 0);
      check("reset_count", o_cycle_count, 0);

      // Continuous: HALT fetched on the 3rd advance, DONE after 7 advances.
      clr_tally();
      cyc(.st(1));
      cyc(); cyc(); cyc(.ht(1));
      for (int i = 0; i < DRAIN; i++) cyc();
      check("cont_done_early", o_done, 0);
      cyc();
      check("cont_pc_advances", t_pc, 3);
      check("cont_pipe_advances", t_pipe, 7);
      check("cont_done", o_done, 1);
      check("cont_count", o_cycle_count, CNT_EN ? 7 : 0);
      cyc(.st(1), .sp(1));
      check("done_sticky", o_done, 1);

      // Step mode: nothing moves without i_step; five pulses give five advances.
      cyc(.rs(1));
      cyc(.st(1), .md(1));
      clr_tally();
      for (int i = 0; i < 10; i++) cyc();
      check("step_idle_pipe", t_pipe, 0);
      check("step_idle_count", o_cycle_count, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(.sp(1));
         cyc();
      end
      check("step_pipe", t_pipe, 5);
      check("step_count", o_cycle_count, CNT_EN ? 5 : 0);
      check("step_running", o_running, 1);

      // Hazards in RUN.
      cyc(.rs(1));
      cyc(.st(1));
      cyc(.lu(1), .br(1));
      check("lubr_pc", o_pc_en, 0);
      check("lubr_if_id", o_if_id_en, 0);
      check("lubr_bubble", o_id_ex_bubble, 1);
      check("lubr_flush", o_if_id_flush, 0);
      check("lubr_pipe", o_pipe_en, 1);
      cyc(.br(1));
      check("br_flush", o_if_id_flush, 1);
      check("br_pc", o_pc_en, 1);

      // DRAIN ignores hazard and halt inputs.
      cyc(.ht(1));
      clr_tally();
      for (int i = 0; i < DRAIN; i++) cyc(.ht(1), .lu(1), .br(1));
      check("drain_flush", t_flush, DRAIN);
      check("drain_pc", t_pc, 0);
      cyc();
      check("drain_done", o_done, 1);

      // Asynchronous reset between edges in the 2nd drain cycle.
      cyc(.rs(1));
      cyc(.st(1));
      cyc(.ht(1));
      cyc();
      @(posedge clk);
      #1;
      i_halt_fetched = 1'b0;
      check("pre_rst_flush", o_if_id_flush, 1);
      #2;
      i_reset = 1'b1;
      #1;
      check("async_rst_flush", o_if_id_flush, 0);
      check("async_rst_pipe", o_pipe_en, 0);
      check("async_rst_running", o_running, 0);
      check("async_rst_count", o_cycle_count, 0);
      cyc();
      cyc(.st(1));
      cyc(.ht(1));
      for (int i = 0; i < DRAIN; i++) cyc();
      cyc();
      check("restart_done", o_done, 1);
      check("restart_count", o_cycle_count, CNT_EN ? 5 : 0);

      // Randomized run, checked cycle by cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         cyc(.st($urandom_range(0, 3) == 0), .sp($urandom_range(0, 1) == 1),
             .md($urandom_range(0, 1) == 1), .ht($urandom_range(0, 7) == 0),
             .lu($urandom_range(0, 4) == 0), .br($urandom_range(0, 4) == 0),
             .rs($urandom_range(0, 99) == 0));
      end
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Execution sequencer for the 5-stage MIPS pipeline. Generates the write enables, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Supports continuous and single-step execution, applies load-use stalls and branch flushes, and drains the pipeline after a HALT so that HALT retires through WB before the pipeline freezes. It sits between the debug unit (start/step/mode), the hazard unit and the datapath registers.

## Interface
- NB_CNT, 32, width of the executed-cycle counter
- DRAIN_CYCLES, 4, advances after the HALT-fetch advance needed to retire HALT through WB
- i_clock  in  1  pipeline clock; all state changes on rising edge
- i_reset  in  1  reset; asynchronous and active-high
- i_mode_step  in  1  1 = single-step mode, 0 = continuous; sampled only when i_start is accepted
- i_start  in  1  one-cycle pulse; starts execution from IDLE
- i_step  in  1  one-cycle pulse; one pipeline advance in step mode
- i_halt_fetched  in  1  IF stage holds a HALT opcode this cycle
- i_load_use_hazard  in  1  stall request from the hazard unit
- i_branch_taken  in  1  branch/jump resolved taken in ID
- o_pc_en  out  1  PC write enable
- o_if_id_en  out  1  IF/ID write enable
- o_pipe_en  out  1  ID/EX, EX/MEM, MEM/WB write enable
- o_if_id_flush  out  1  load NOP into IF/ID on this advance
- o_id_ex_bubble  out  1  load NOP controls into ID/EX on this advance
- o_running  out  1  state is RUN, STEP_WAIT or DRAIN
- o_done  out  1  state is DONE
- o_cycle_count  out  NB_CNT  number of advance cycles since reset

## Operation
- States: IDLE, RUN, STEP_WAIT, DRAIN, DONE. Reset state is IDLE.
- "Advance" is an internal combinational signal: 1 in RUN; in STEP_WAIT and DRAIN it is 1 when i_step=1 if the latched mode is step, otherwise 1.
- IDLE: all enables 0. i_start=1 latches i_mode_step and moves to STEP_WAIT (step) or RUN (continuous). i_step is ignored.
- RUN/STEP_WAIT advance with no hazard: o_pc_en=o_if_id_en=o_pipe_en=1.
- Load-use on an advance: o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, o_pipe_en=1.
- Branch taken on an advance: o_if_id_flush=1, with PC and pipe enables at 1.
- Load-use and branch in the same cycle: the stall wins and the flush is suppressed; the branch re-resolves on the next advance.
- i_halt_fetched=1 on a RUN/STEP_WAIT advance without load-use: a normal advance, then transition to DRAIN with drain counter=0. On a non-advance cycle or a stalled cycle it is ignored.
- DRAIN advance: o_pc_en=0, o_if_id_en=1, o_if_id_flush=1, o_pipe_en=1, o_id_ex_bubble=0. Hazard and halt inputs are ignored. The drain counter increments on each advance. The advance taken with counter=DRAIN_CYCLES-1 moves to DONE.
- DONE: all enables 0, o_done=1. i_start and i_step are ignored. Only i_reset leaves DONE.
- In non-advance cycles all enable, flush and bubble outputs are 0.
- i_step is ignored in continuous mode. i_start is ignored outside IDLE.

## Timing
- Enable, flush and bubble outputs are combinational from the state and the current-cycle inputs; they take effect at the same rising edge.
- o_running, o_done and o_cycle_count are registered.
- Reset (asynchronous, at any point including mid-DRAIN): state=IDLE, drain counter=0, latched mode=0, o_cycle_count=0. All outputs are 0 immediately, without waiting for a clock edge.
- Step mode: exactly one advance per i_step pulse. An i_step held high for N cycles produces N advances.
- o_cycle_count increments at the edge ending each advance cycle, in RUN, STEP_WAIT and DRAIN. It saturates at 2^NB_CNT-1 and holds in IDLE and DONE.
- Minimum program: start → HALT fetched on the first advance → DONE after 1+DRAIN_CYCLES advances.

## Configuration
- PIPE_CYCLE_COUNT_EN defined: the NB_CNT-bit counter is built and o_cycle_count behaves as in Timing.
- PIPE_CYCLE_COUNT_EN undefined: no counter register is built; o_cycle_count is tied to 0. All other behaviour is identical.

## Test plan
- Continuous: start with mode=0, HALT fetched on advance 3 → o_pc_en drops after the 3rd advance; DONE after 3+4=7 advances; o_cycle_count=7.
- Step mode: start with mode=1, no i_step for 10 cycles → all enables 0, count=0. Five i_step pulses → exactly 5 cycles with o_pipe_en=1, count=5.
- Hazards: load-use and branch asserted together in RUN → o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, o_if_id_flush=0, o_pipe_en=1. Branch alone → o_if_id_flush=1, o_pc_en=1.
- DRAIN: inject load-use and halt during DRAIN → ignored; o_if_id_flush=1 and o_pc_en=0 on all 4 drain advances; then o_done=1.
- Reset: assert i_reset between edges in the 2nd drain cycle → outputs 0 before the next edge; state IDLE, count=0. A new start runs normally.
- Macro off: repeat the first scenario → o_cycle_count stays 0; DONE timing unchanged.
